// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a length-prefixed, XOR-checksummed UART byte stream into
// little-endian words, writes them to instruction memory and releases the core on success.
module imem_boot_loader #(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic              busy
);

  typedef enum logic [2:0] {S_LEN, S_DATA, S_SUM, S_DONE, S_ERR} state_t;

  state_t            state, state_nx;
  logic [1:0]        byte_cnt;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   len;
  logic [31:0]       shreg;
  logic [7:0]        csum;
  logic              seen_byte;

  logic [31:0]       shifted;
  logic [ADDR_W:0]   word_cnt_inc;
  logic              last_byte;
  logic              last_word;

  // Bytes enter at the top so the first byte of a word ends up in [7:0].
  assign shifted      = {rx_data, shreg[31:8]};
  assign word_cnt_inc = word_cnt + (ADDR_W+1)'(1);
  assign last_byte    = (byte_cnt == 2'd3);
  assign last_word    = (word_cnt_inc == len);

  always_comb begin
    state_nx = state;
    case (state)
      S_LEN: begin
        if (rx_valid && last_byte) begin
          if (shifted == 32'd0)                 state_nx = S_SUM;
          else if (shifted > 32'(MAX_WORDS))    state_nx = S_ERR;
          else                                  state_nx = S_DATA;
        end
      end
      S_DATA: if (rx_valid && last_byte && last_word) state_nx = S_SUM;
      S_SUM:  if (rx_valid) state_nx = (rx_data == csum) ? S_DONE : S_ERR;
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LEN;
      byte_cnt   <= 2'd0;
      word_cnt   <= '0;
      len        <= '0;
      shreg      <= 32'd0;
      csum       <= 8'd0;
      seen_byte  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
    end else begin
      state   <= state_nx;
      imem_we <= 1'b0;
      if (rx_valid && (state == S_LEN || state == S_DATA || state == S_SUM))
        seen_byte <= 1'b1;
      if (rx_valid && (state == S_LEN || state == S_DATA)) begin
        shreg    <= shifted;
        byte_cnt <= byte_cnt + 2'd1;
      end
      // Only the low bits are kept: anything larger is rejected before use.
      if (rx_valid && state == S_LEN && last_byte)
        len <= shifted[ADDR_W:0];
      if (rx_valid && state == S_DATA) begin
        csum <= csum ^ rx_data;
        if (last_byte) begin
          imem_we    <= 1'b1;
          imem_addr  <= word_cnt[ADDR_W-1:0];
          imem_wdata <= shifted;
          word_cnt   <= word_cnt_inc;
        end
      end
    end
  end

  assign load_done = (state == S_DONE);
  assign load_err  = (state == S_ERR);
  assign cpu_rst   = (state != S_DONE);
  assign busy      = seen_byte && (state == S_LEN || state == S_DATA || state == S_SUM);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: directed and random byte streams checked against a
// stream-level model of the expected writes and final load status.
module tb_imem_boot_loader;

  localparam int ADDR_W    = 10;
  localparam int MAX_WORDS = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [7:0]        rx_data = 8'd0;
  logic              rx_valid = 1'b0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst, load_done, load_err, busy;

  imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  stim[$];
  logic [41:0] got[$];
  logic [41:0] exp_w[$];
  int          exp_st;    // 0 loading, 1 done, 2 error
  int          exp_tidx;  // index of the byte that ends the load, -1 if none

  // Every high cycle of imem_we is one recorded write.
  always @(negedge clk)
    if (imem_we) got.push_back({imem_addr, imem_wdata});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Stream-level model: parse length, words and checksum straight from the byte list.
  task automatic model();
    logic [31:0] n;
    logic [7:0]  cs;
    int          si;
    exp_w.delete();
    exp_st   = 0;
    exp_tidx = -1;
    if (stim.size() < 4) return;
    n = {stim[3], stim[2], stim[1], stim[0]};
    if (n > MAX_WORDS) begin
      exp_st = 2; exp_tidx = 3; return;
    end
    cs = 8'd0;
    for (int w = 0; w < int'(n); w++) begin
      if (4 + 4*w + 3 >= stim.size()) return;
      exp_w.push_back({ADDR_W'(w), stim[4*w+7], stim[4*w+6], stim[4*w+5], stim[4*w+4]});
      for (int k = 0; k < 4; k++) cs ^= stim[4 + 4*w + k];
    end
    si = 4 + 4*int'(n);
    if (si < stim.size()) begin
      exp_st   = (stim[si] == cs) ? 1 : 2;
      exp_tidx = si;
    end
  endtask

  task automatic chk_status(input string tag, input int st);
    chk({tag, ".done"},    64'(load_done), 64'(st == 1));
    chk({tag, ".err"},     64'(load_err),  64'(st == 2));
    chk({tag, ".cpu_rst"}, 64'(cpu_rst),   64'(st != 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got.delete();
    chk("rst.we",    64'(imem_we),    64'd0);
    chk("rst.addr",  64'(imem_addr),  64'd0);
    chk("rst.wdata", 64'(imem_wdata), 64'd0);
    chk("rst.busy",  64'(busy),       64'd0);
    chk_status("rst", 0);
  endtask

  // Drives the current stim list (called at a negedge) and checks it against the model.
  task automatic run(input string tag, input int gap);
    model();
    for (int i = 0; i < stim.size(); i++) begin
      rx_valid = 1'b1;
      rx_data  = stim[i];
      @(negedge clk);
      rx_valid = 1'b0;
      if (i == 0) chk({tag, ".busy"}, 64'(busy), 64'd1);
      if (i == exp_tidx) chk_status({tag, ".edge"}, exp_st);
      repeat (gap < 0 ? $urandom_range(0, 3) : gap) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk({tag, ".nwr"}, 64'(got.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got.size(); i++)
      chk({tag, ".wr"}, 64'(got[i]), 64'(exp_w[i]));
    chk_status({tag, ".end"}, exp_st);
    if (exp_st == 0) chk({tag, ".busy_end"}, 64'(busy), 64'(stim.size() > 0));
  endtask

  task automatic load_happy(input logic [7:0] sum_xor);
    logic [7:0] b[13] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                          8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
    stim.delete();
    foreach (b[i]) stim.push_back(b[i]);
    stim[12] = stim[12] ^ sum_xor;
  endtask

  task automatic load_random(input int n, input bit corrupt);
    logic [7:0]  cs = 8'd0;
    logic [7:0]  b;
    logic [31:0] nn = n;
    stim.delete();
    for (int k = 0; k < 4; k++) stim.push_back(nn[8*k +: 8]);
    for (int i = 0; i < 4*n; i++) begin
      b = 8'($urandom);
      cs ^= b;
      stim.push_back(b);
    end
    stim.push_back(corrupt ? cs ^ 8'($urandom_range(1, 255)) : cs);
    for (int i = 0; i < 3; i++) stim.push_back(8'($urandom));
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Happy path, spaced bytes, with independent constant expectations too.
    load_happy(8'h00);
    run("happy_gap3", 3);
    chk("happy.w0", 64'(got.size() > 0 ? got[0] : 42'd0), {22'd0, 10'd0, 32'h00100513});
    chk("happy.w1", 64'(got.size() > 1 ? got[1] : 42'd0), {22'd0, 10'd1, 32'h00200593});
    chk("happy.done", 64'(load_done), 64'd1);

    // Same image back-to-back, then trailing bytes that must be ignored.
    do_reset();
    load_happy(8'h00);
    stim.push_back(8'hAA); stim.push_back(8'h55); stim.push_back(8'h01);
    stim.push_back(8'h02); stim.push_back(8'h03);
    run("happy_b2b", 0);

    do_reset();
    load_happy(8'h01);
    run("badsum", 1);
    chk("badsum.err", 64'(load_err), 64'd1);

    do_reset();
    stim.delete();
    stim = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00};
    run("oversize", 0);

    do_reset();
    stim = '{8'h00, 8'h04, 8'h00, 8'h00};  // exactly MAX_WORDS is accepted
    run("maxlen_hdr", 0);

    do_reset();
    stim = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run("empty", 2);

    // Reset after 6 data bytes, then a clean 1-word image.
    do_reset();
    stim = '{8'h02, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h77, 8'h66};
    run("abort", 0);
    do_reset();
    stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    run("after_abort", 1);
    chk("after_abort.w0", 64'(got.size() > 0 ? got[0] : 42'd0), {22'd0, 10'd0, 32'h12345678});

    // Random images, gaps and checksum corruption.
    for (int it = 0; it < 10; it++) begin
      do_reset();
      load_random($urandom_range(1, 6), ($urandom_range(0, 3) == 0));
      run($sformatf("rand%0d", it), (it % 3 == 0) ? 0 : -1);
    end

    // Random oversize lengths.
    for (int it = 0; it < 3; it++) begin
      logic [31:0] n;
      do_reset();
      n = 32'(MAX_WORDS + 1) + $urandom_range(0, 100000);
      stim.delete();
      for (int k = 0; k < 4; k++) stim.push_back(n[8*k +: 8]);
      for (int k = 0; k < 6; k++) stim.push_back(8'($urandom));
      run($sformatf("rand_over%0d", it), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
